// File: rtl/ram_bist_pkg.sv
// Shared encodings for the RAM BIST engine: FSM states, access phase, mode values
// and the March C- element table (direction, op count, read/write pattern select).
package ram_bist_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_INIT   = 2'd1,
      ST_RUN    = 2'd2,
      ST_FINISH = 2'd3
   } state_t;

   typedef enum logic {
      PH_SETUP  = 1'b0,
      PH_ACCESS = 1'b1
   } phase_t;

   localparam logic MODE_MARCH = 1'b0;
   localparam logic MODE_FILL  = 1'b1;

   // One element = per-address op list: optional read then optional write.
   // *_inv selects ~BG instead of BG as the data pattern.
   typedef struct packed {
      logic down;
      logic has_rd;
      logic rd_inv;
      logic has_wr;
      logic wr_inv;
   } elem_t;

   localparam int         ELEM_CNT  = 6;
   localparam logic [2:0] LAST_ELEM = 3'(ELEM_CNT - 1);
   // Direction bit per element index; E3 and E4 count down.
   localparam logic [7:0] ELEM_DOWN = 8'b0001_1000;

   localparam elem_t FILL_ELEM = '{down: 1'b0, has_rd: 1'b0, rd_inv: 1'b0,
                                   has_wr: 1'b1, wr_inv: 1'b0};

   function automatic elem_t march_elem(input logic [2:0] idx);
      elem_t e;
      e      = '0;
      e.down = ELEM_DOWN[idx];
      case (idx)
         3'd0: begin e.has_wr = 1'b1; end
         3'd1: begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.wr_inv = 1'b1; end
         3'd2: begin e.has_rd = 1'b1; e.rd_inv = 1'b1; e.has_wr = 1'b1; end
         3'd3: begin e.has_rd = 1'b1; e.has_wr = 1'b1; e.wr_inv = 1'b1; end
         3'd4: begin e.has_rd = 1'b1; e.rd_inv = 1'b1; e.has_wr = 1'b1; end
         3'd5: begin e.has_rd = 1'b1; end
         default: e = '0;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/ram_bist_engine_if.sv
// CPU-side RAM controller port as driven by the BIST engine (master) and
// served by the controller (slave); bist_active tells the IO-block mux who owns it.
interface ram_bist_engine_if;
   logic        bist_active;
   logic [15:0] addr_out;
   logic        web_out;
   logic [7:0]  wdata_out;
   logic [7:0]  rdata_in;

   modport master (
      output bist_active, addr_out, web_out, wdata_out,
      input  rdata_in
   );

   modport slave (
      input  bist_active, addr_out, web_out, wdata_out,
      output rdata_in
   );
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter with load to 0 or DEPTH-1 and a last-address flag.
// Registered count, one step per enabled cycle; never steps past the end value.
module ram_bist_addr_gen #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          wb_clk_i,
   input  logic          rst_n,
   input  logic          load,
   input  logic          load_top,
   input  logic          step,
   input  logic          down,
   output logic [AW-1:0] addr,
   output logic          last
);

   localparam logic [AW-1:0] TOP = AW'(DEPTH - 1);

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (load) begin
         addr <= load_top ? TOP : '0;
      end else if (step && !last) begin
         addr <= down ? addr - AW'(1) : addr + AW'(1);
      end
   end

   // Explicit end-value compare keeps the element boundary independent of wrap.
   assign last = down ? (addr == '0) : (addr == TOP);

endmodule

// File: rtl/ram_bist_engine.sv
// March C- / fill engine driving the RAM controller port; every access is SETUP+ACCESS (2 cycles).
// Stops at the first miscompare, pulses done in FINISH; start is honoured only in IDLE.
module ram_bist_engine
   import ram_bist_pkg::*;
#(
   parameter int          DEPTH = 4096,
   parameter logic [7:0]  BG    = 8'h00
) (
   input  logic                     wb_clk_i,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     mode,
   input  logic [7:0]               fill_value,
   ram_bist_engine_if.master        bus,
   output logic                     done,
   output logic                     fail,
   output logic [15:0]              fail_addr,
   output logic [7:0]               fail_data
);

   localparam int AW = $clog2(DEPTH);

   state_t     state_q, state_d;
   phase_t     phase_q, phase_d;
   logic [2:0] elem_q, elem_d;
   logic       op_q, op_d;
   logic       mode_q;
   logic [7:0] fill_q;

   logic          addr_load, addr_load_top, addr_step, addr_last;
   logic [AW-1:0] addr;
   logic          start_acc, miscompare;

   elem_t      cur;
   logic       is_rd, is_wr, last_op, last_elem, next_down;
   logic [7:0] exp_dat, wr_dat;

   ram_bist_addr_gen #(.DEPTH(DEPTH), .AW(AW)) u_addr_gen (
      .wb_clk_i (wb_clk_i),
      .rst_n    (rst_n),
      .load     (addr_load),
      .load_top (addr_load_top),
      .step     (addr_step),
      .down     (cur.down),
      .addr     (addr),
      .last     (addr_last)
   );

   // Current op decode: read (if any) is op 0, write follows as op 1.
   always_comb begin
      cur       = (mode_q == MODE_FILL) ? FILL_ELEM : march_elem(elem_q);
      is_rd     = cur.has_rd && !op_q;
      is_wr     = cur.has_wr && (op_q || !cur.has_rd);
      last_op   = op_q || !(cur.has_rd && cur.has_wr);
      last_elem = (mode_q == MODE_FILL) || (elem_q == LAST_ELEM);
      next_down = ELEM_DOWN[3'(elem_q + 3'd1)];
      exp_dat   = cur.rd_inv ? ~BG : BG;
      wr_dat    = (mode_q == MODE_FILL) ? fill_q : (cur.wr_inv ? ~BG : BG);
   end

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= PH_SETUP;
         elem_q  <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         elem_q  <= elem_d;
         op_q    <= op_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      phase_d       = phase_q;
      elem_d        = elem_q;
      op_d          = op_q;
      addr_load     = 1'b0;
      addr_load_top = 1'b0;
      addr_step     = 1'b0;
      start_acc     = 1'b0;
      miscompare    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               start_acc = 1'b1;
               state_d   = ST_INIT;
            end
         end
         ST_INIT: begin
            addr_load = 1'b1;
            elem_d    = '0;
            op_d      = 1'b0;
            phase_d   = PH_SETUP;
            state_d   = ST_RUN;
         end
         ST_RUN: begin
            if (phase_q == PH_SETUP) begin
               phase_d = PH_ACCESS;
            end else begin
               phase_d = PH_SETUP;
               if (is_rd && (bus.rdata_in != exp_dat)) begin
                  miscompare = 1'b1;
                  state_d    = ST_FINISH;
               end else if (!last_op) begin
                  op_d = 1'b1;
               end else begin
                  op_d = 1'b0;
                  if (!addr_last) begin
                     addr_step = 1'b1;
                  end else if (last_elem) begin
                     state_d = ST_FINISH;
                  end else begin
                     elem_d        = 3'(elem_q + 3'd1);
                     addr_load     = 1'b1;
                     addr_load_top = next_down;
                  end
               end
            end
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (!rst_n) begin
         mode_q    <= MODE_MARCH;
         fill_q    <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else if (start_acc) begin
         mode_q    <= mode;
         fill_q    <= fill_value;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_data <= '0;
      end else if (miscompare) begin
         fail      <= 1'b1;
         fail_addr <= bus.addr_out;
         fail_data <= bus.rdata_in;
      end
   end

   // Write strobe only in ACCESS so the controller's registered bank select has settled.
   assign bus.bist_active = (state_q != ST_IDLE);
   assign bus.addr_out    = 16'(addr);
   assign bus.wdata_out   = (state_q == ST_RUN) ? wr_dat : 8'h00;
   assign bus.web_out     = !((state_q == ST_RUN) && (phase_q == PH_ACCESS) && is_wr);
   assign done            = (state_q == ST_FINISH);

endmodule

// File: tb/tb_ram_bist_engine.sv
// Bench for ram_bist_engine: behavioural 2-cycle RAM with an optional stuck-at bit,
// and a March/fill reference built from the element list.
module tb_ram_bist_engine;

   localparam int         DEPTH = 16;
   localparam logic [7:0] BG    = 8'h00;

   localparam int E_DN [6] = '{0, 0, 0, 1, 1, 0};
   localparam int E_RD [6] = '{-1, 0, 1, 0, 1, 0};
   localparam int E_WR [6] = '{0, 1, 0, 1, 0, -1};

   logic        wb_clk_i = 1'b0;
   logic        rst_n;
   logic        start;
   logic        mode;
   logic [7:0]  fill_value;
   logic        done;
   logic        fail;
   logic [15:0] fail_addr;
   logic [7:0]  fail_data;

   ram_bist_engine_if bus();

   ram_bist_engine #(.DEPTH(DEPTH), .BG(BG)) dut (
      .wb_clk_i   (wb_clk_i),
      .rst_n      (rst_n),
      .start      (start),
      .mode       (mode),
      .fill_value (fill_value),
      .bus        (bus),
      .done       (done),
      .fail       (fail),
      .fail_addr  (fail_addr),
      .fail_data  (fail_data)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int checks = 0;
   int errors = 0;

   bit         fault_en   = 1'b0;
   int         fault_addr = 0;
   logic [7:0] fault_mask = 8'h00;
   logic [7:0] fault_val  = 8'h00;

   logic [7:0] ram [DEPTH];
   logic [7:0] gm  [DEPTH];

   typedef struct {
      bit         wr;
      int         addr;
      logic [7:0] dat;
   } op_t;

   op_t        exp_q[$];
   int         n_ops;
   bit         efail;
   int         efaddr;
   logic [7:0] efdata;

   function automatic logic [7:0] faulty(input int a, input logic [7:0] d);
      if (fault_en && a == fault_addr) return (d & ~fault_mask) | (fault_val & fault_mask);
      return d;
   endfunction

   // Controller model: write lands on the edge closing the web_out-low cycle.
   always @(posedge wb_clk_i) begin
      if (bus.web_out === 1'b0) ram[bus.addr_out[3:0]] <= faulty(int'(bus.addr_out[3:0]), bus.wdata_out);
   end
   assign bus.rdata_in = ram[bus.addr_out[3:0]];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void push_op(input bit wr, input int a, input logic [7:0] d);
      op_t o;
      o.wr = wr; o.addr = a; o.dat = d;
      exp_q.push_back(o);
   endfunction

   // Expected op stream plus the outcome of running it over a faulty RAM image.
   function automatic void build_ops(input bit m, input logic [7:0] fv);
      exp_q.delete();
      if (m) begin
         for (int a = 0; a < DEPTH; a++) push_op(1'b1, a, fv);
      end else begin
         for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
               int a;
               a = (E_DN[e] == 1) ? DEPTH - 1 - k : k;
               if (E_RD[e] >= 0) push_op(1'b0, a, (E_RD[e] == 1) ? ~BG : BG);
               if (E_WR[e] >= 0) push_op(1'b1, a, (E_WR[e] == 1) ? ~BG : BG);
            end
         end
      end
      gm = ram;
      n_ops = exp_q.size(); efail = 1'b0; efaddr = 0; efdata = 8'h00;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].wr) begin
            gm[exp_q[i].addr] = faulty(exp_q[i].addr, exp_q[i].dat);
         end else if (gm[exp_q[i].addr] !== exp_q[i].dat) begin
            efail = 1'b1; efaddr = exp_q[i].addr; efdata = gm[exp_q[i].addr];
            n_ops = i + 1;
            break;
         end
      end
   endfunction

   task automatic run_bist(input bit m, input logic [7:0] fv, input int abort_op,
                           input int busy_op, input bit start_on_finish);
      logic [15:0] a0;
      logic [7:0]  d0;
      build_ops(m, fv);
      @(negedge wb_clk_i);
      mode = m; fill_value = fv; start = 1'b1;
      @(negedge wb_clk_i);
      start = 1'b0; mode = 1'($urandom); fill_value = 8'($urandom);
      chk("init_active", bus.bist_active, 1'b1);
      chk("init_web", bus.web_out, 1'b1);
      chk("init_fail_clr", fail, 1'b0);
      chk("init_fail_addr_clr", fail_addr, 16'h0);
      chk("init_fail_data_clr", fail_data, 8'h00);
      for (int i = 0; i < n_ops; i++) begin
         @(negedge wb_clk_i);
         if (i == abort_op) begin
            rst_n = 1'b0;
            @(negedge wb_clk_i);
            chk("abort_active", bus.bist_active, 1'b0);
            chk("abort_web", bus.web_out, 1'b1);
            chk("abort_done", done, 1'b0);
            rst_n = 1'b1;
            @(negedge wb_clk_i);
            chk("abort_idle_active", bus.bist_active, 1'b0);
            chk("abort_idle_done", done, 1'b0);
            return;
         end
         if (i == busy_op) begin
            start = 1'b1; mode = ~m; fill_value = ~fv;
         end
         chk("setup_addr", bus.addr_out, exp_q[i].addr);
         chk("setup_web", bus.web_out, 1'b1);
         chk("run_done", done, 1'b0);
         chk("run_active", bus.bist_active, 1'b1);
         a0 = bus.addr_out; d0 = bus.wdata_out;
         @(negedge wb_clk_i);
         start = 1'b0;
         chk("access_addr_stable", bus.addr_out, a0);
         chk("access_wdata_stable", bus.wdata_out, d0);
         chk("access_web", bus.web_out, !exp_q[i].wr);
         if (exp_q[i].wr) chk("access_wdata", bus.wdata_out, exp_q[i].dat);
      end
      @(negedge wb_clk_i);
      chk("finish_done", done, 1'b1);
      chk("finish_active", bus.bist_active, 1'b1);
      chk("finish_fail", fail, efail);
      chk("finish_fail_addr", fail_addr, efaddr);
      chk("finish_fail_data", fail_data, efdata);
      if (start_on_finish) begin
         start = 1'b1; mode = ~m;
      end
      @(negedge wb_clk_i);
      start = 1'b0;
      chk("idle_done", done, 1'b0);
      chk("idle_active", bus.bist_active, 1'b0);
      chk("idle_web", bus.web_out, 1'b1);
      chk("idle_fail_sticky", fail, efail);
      if (start_on_finish) begin
         @(negedge wb_clk_i);
         chk("no_restart_active", bus.bist_active, 1'b0);
      end
      for (int a = 0; a < DEPTH; a++) chk("ram_image", ram[a], gm[a]);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0; fill_value = 8'h00;
      repeat (3) @(negedge wb_clk_i);
      chk("rst_active", bus.bist_active, 1'b0);
      chk("rst_web", bus.web_out, 1'b1);
      chk("rst_done", done, 1'b0);
      chk("rst_fail", fail, 1'b0);
      chk("rst_fail_addr", fail_addr, 16'h0);
      chk("rst_fail_data", fail_data, 8'h00);
      chk("rst_addr", bus.addr_out, 16'h0);
      chk("rst_wdata", bus.wdata_out, 8'h00);
      rst_n = 1'b1;
      @(negedge wb_clk_i);

      // Clean March C- pass.
      run_bist(1'b0, 8'h00, -1, -1, 1'b0);

      // Stuck-at-0 on bit 3 of address 5.
      fault_en = 1'b1; fault_addr = 5; fault_mask = 8'h08; fault_val = 8'h00;
      run_bist(1'b0, 8'h00, -1, -1, 1'b0);
      chk("sa0_fail", fail, 1'b1);
      chk("sa0_fail_addr", fail_addr, 16'h0005);
      chk("sa0_fail_data", fail_data, 8'hF7);

      // Fresh start after a failure, with start pulses while busy and on FINISH.
      fault_en = 1'b0;
      run_bist(1'b0, 8'h00, -1, 7, 1'b1);

      // Fill A5 with a busy start trying to switch to March.
      run_bist(1'b1, 8'hA5, -1, 3, 1'b1);
      for (int a = 0; a < DEPTH; a++) chk("fill_a5", ram[a], 8'hA5);

      // Reset in the middle of E3 (E3 starts at op 80), then a full clean pass.
      run_bist(1'b0, 8'h00, 85, -1, 1'b0);
      run_bist(1'b0, 8'h00, -1, -1, 1'b0);

      // Randomised single-bit stuck faults and fill values.
      for (int it = 0; it < 5; it++) begin
         fault_en   = 1'b1;
         fault_addr = int'($urandom_range(0, DEPTH - 1));
         fault_mask = 8'h01 << $urandom_range(0, 7);
         fault_val  = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
         run_bist(it >= 3, 8'($urandom), -1, int'($urandom_range(0, 15)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
